// File: rtl/exp_cordic_iter_ctrl.sv
// Iteration controller for the hyperbolic CORDIC exponential datapath: sequences
// load/iterate/done, repeats indices 4 and 13, and drives the operand mux select.
module exp_cordic_iter_ctrl #(
    parameter int ITER  = 16,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             beg_fsm,
    input  logic             ack_fsm,
    input  logic             z_sign,
    output logic             ms_sel,
    output logic             load_en,
    output logic [IDX_W-1:0] iter_idx,
    output logic             d_dir,
    output logic             busy,
    output logic             ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ITER);
    localparam logic [IDX_W-1:0] REP_A    = IDX_W'(4);
    localparam logic [IDX_W-1:0] REP_B    = IDX_W'(13);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             rep, rep_nxt;

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        idx_nxt   = iter_idx;
        rep_nxt   = rep;
        case (state)
            S_IDLE: begin
                if (beg_fsm) begin
                    state_nxt = S_LOAD;
                    idx_nxt   = '0;
                end
            end
            S_LOAD: begin
                state_nxt = S_ITER;
                idx_nxt   = IDX_W'(1);
                rep_nxt   = 1'b0;
            end
            S_ITER: begin
                // A pending repeat takes priority over finishing, so index 13 runs
                // twice even when it is the last index.
                if ((iter_idx == REP_A || iter_idx == REP_B) && !rep) begin
                    rep_nxt = 1'b1;
                end else if (iter_idx == LAST_IDX) begin
                    state_nxt = S_DONE;
                    rep_nxt   = 1'b0;
                end else begin
                    idx_nxt = iter_idx + IDX_W'(1);
                    rep_nxt = 1'b0;
                end
            end
            S_DONE: begin
                if (ack_fsm) begin
                    state_nxt = S_IDLE;
                    idx_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                idx_nxt   = '0;
                rep_nxt   = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update
    // together from values sampled at the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            iter_idx <= '0;
            rep      <= 1'b0;
            ms_sel   <= 1'b0;
            load_en  <= 1'b0;
            busy     <= 1'b0;
            ready    <= 1'b0;
        end else begin
            state    <= state_nxt;
            iter_idx <= idx_nxt;
            rep      <= rep_nxt;
            // Outputs are decoded from the next state so they come straight from flops.
            ms_sel   <= (state_nxt == S_ITER) || (state_nxt == S_DONE);
            load_en  <= (state_nxt == S_LOAD) || (state_nxt == S_ITER);
            busy     <= (state_nxt == S_LOAD) || (state_nxt == S_ITER);
            ready    <= (state_nxt == S_DONE);
        end
    end

    // Direction follows the live Z sign so it is valid within the same iteration cycle.
    assign d_dir = (state == S_ITER) & ~z_sign;

endmodule

// File: tb/tb_exp_cordic_iter_ctrl.sv
// Randomized self-checking bench for exp_cordic_iter_ctrl; two instances cover
// ITER=16 and ITER=13 against a queue-based reference of the index schedule.
module tb_exp_cordic_iter_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic z_sign = 1'b0;
    logic beg16 = 1'b0, ack16 = 1'b0, beg13 = 1'b0, ack13 = 1'b0;
    logic ms16, le16, dd16, bz16, rd16;
    logic ms13, le13, dd13, bz13, rd13;
    logic [4:0] ix16, ix13;

    int total = 0;
    int bad   = 0;
    int sel   = 16;

    always #5 clk = ~clk;

    exp_cordic_iter_ctrl #(.ITER(16), .IDX_W(5)) dut16 (
        .clk(clk), .rst(rst), .beg_fsm(beg16), .ack_fsm(ack16), .z_sign(z_sign),
        .ms_sel(ms16), .load_en(le16), .iter_idx(ix16), .d_dir(dd16),
        .busy(bz16), .ready(rd16)
    );

    exp_cordic_iter_ctrl #(.ITER(13), .IDX_W(5)) dut13 (
        .clk(clk), .rst(rst), .beg_fsm(beg13), .ack_fsm(ack13), .z_sign(z_sign),
        .ms_sel(ms13), .load_en(le13), .iter_idx(ix13), .d_dir(dd13),
        .busy(bz13), .ready(rd13)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input bit ms, input bit le, input bit bz,
                              input bit rd, input bit dd, input int idx);
        if (sel == 16) begin
            check({tag, ".ms_sel"}, ms16, ms);
            check({tag, ".load_en"}, le16, le);
            check({tag, ".busy"}, bz16, bz);
            check({tag, ".ready"}, rd16, rd);
            check({tag, ".d_dir"}, dd16, dd);
            check({tag, ".iter_idx"}, ix16, idx);
        end else begin
            check({tag, ".ms_sel"}, ms13, ms);
            check({tag, ".load_en"}, le13, le);
            check({tag, ".busy"}, bz13, bz);
            check({tag, ".ready"}, rd13, rd);
            check({tag, ".d_dir"}, dd13, dd);
            check({tag, ".iter_idx"}, ix13, idx);
        end
    endtask

    task automatic set_beg(input bit v);
        if (sel == 16) beg16 = v; else beg13 = v;
    endtask

    task automatic set_ack(input bit v);
        if (sel == 16) ack16 = v; else ack13 = v;
    endtask

    function automatic bit cur_le();
        return (sel == 16) ? le16 : le13;
    endfunction

    // One full transaction. hold: DONE cycles with ack low; toggle: random beg during
    // ITER; both: ack and beg together in DONE; abort_at: assert rst at that index.
    task automatic run(input int last, input int hold, input bit toggle, input bit both,
                       input int abort_at);
        int q[$];
        int le_cnt;
        // Reference schedule: every index 1..last once, 4 and 13 twice.
        for (int i = 1; i <= last; i++) begin
            q.push_back(i);
            if (i == 4 || i == 13) q.push_back(i);
        end

        @(negedge clk);
        set_beg(1'b1);
        @(posedge clk);
        #1 z_sign = 1'($urandom);
        set_beg(1'b0);
        #1 check_outs("load", 0, 1, 1, 0, 0, 0);
        le_cnt = int'(cur_le());

        foreach (q[i]) begin
            @(posedge clk);
            #1 z_sign = 1'($urandom);
            if (toggle) set_beg(1'($urandom));
            if (abort_at != 0 && q[i] == abort_at) begin
                rst = 1'b1;
                #1 check_outs("rst_async", 0, 0, 0, 0, 0, 0);
                set_beg(1'b0);
                repeat (2) @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                repeat (3) begin
                    @(posedge clk);
                    #2 check_outs("post_rst_idle", 0, 0, 0, 0, 0, 0);
                end
                return;
            end
            #1 check_outs($sformatf("iter%0d", i), 1, 1, 1, 0, !z_sign, q[i]);
            le_cnt += int'(cur_le());
        end
        set_beg(1'b0);

        @(posedge clk);
        #1 z_sign = 1'($urandom);
        #1 check_outs("done", 1, 0, 0, 1, 0, last);
        check("load_en_cycles", le_cnt, last + 3);

        repeat (hold) begin
            @(posedge clk);
            #1 z_sign = 1'($urandom);
            #1 check_outs("done_hold", 1, 0, 0, 1, 0, last);
        end

        @(negedge clk);
        set_ack(1'b1);
        if (both) set_beg(1'b1);
        @(posedge clk);
        #2 set_ack(1'b0);
        set_beg(1'b0);
        check_outs("ack_idle", 0, 0, 0, 0, 0, 0);
        repeat (2) begin
            @(posedge clk);
            #2 check_outs("stay_idle", 0, 0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        #1 check_outs("reset", 0, 0, 0, 0, 0, 0);
        sel = 13;
        check_outs("reset13", 0, 0, 0, 0, 0, 0);
        sel = 16;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        run(16, 10, 1'b0, 1'b0, 0);
        run(16, 0, 1'b1, 1'b1, 0);
        run(16, 0, 1'b0, 1'b0, 7);
        run(16, 1, 1'b0, 1'b0, 0);
        sel = 13;
        run(13, 2, 1'b0, 1'b0, 0);
        run(13, 0, 1'b1, 1'b1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exp_cordic_iter_ctrl.md
# exp_cordic_iter_ctrl

Iteration controller for the hyperbolic CORDIC exponential datapath. It sits directly upstream of the 23-bit 2:1 operand muxes and the X/Y/Z iteration registers. It drives the mux select, choosing the initial operand on the load cycle and the fed-back iteration result on every iteration cycle after that. It also sequences the iteration index, including the repeated indices that hyperbolic CORDIC convergence requires, and produces the rotation direction and the done handshake.

## Interface
- ITER, 16: last iteration index; legal range 13..31.
- IDX_W, 5: width of the iteration index.
- clk  in  1  system clock; rising edge.
- rst  in  1  asynchronous, active-high reset.
- beg_fsm  in  1  start request; sampled only in IDLE.
- ack_fsm  in  1  result-consumed acknowledge; sampled only in DONE.
- z_sign  in  1  MSB of the current Z register (1 = negative).
- ms_sel  out  1  select for the operand muxes: 0 = initial operand (D_0), 1 = feedback operand (D_1).
- load_en  out  1  write enable for the X/Y/Z registers.
- iter_idx  out  IDX_W  current shift amount / atanh LUT address.
- d_dir  out  1  rotation direction: 1 = subtract, 0 = add.
- busy  out  1  high in LOAD and ITER.
- ready  out  1  result valid; high in DONE.

## Operation
- The FSM has four states: IDLE, LOAD, ITER and DONE. It is a one-hot or binary encoding with registered outputs, except d_dir.
- IDLE
  - All outputs are 0.
  - beg_fsm=1 moves the FSM to LOAD.
- LOAD (exactly 1 cycle)
  - ms_sel=0, load_en=1, busy=1, iter_idx=0.
  - Next state is ITER with iter_idx=1.
- ITER
  - ms_sel=1, load_en=1, busy=1.
  - An internal rep flag is cleared on entry to ITER.
  - Each cycle, if iter_idx is 4 or 13 and rep=0: set rep=1 and hold iter_idx.
  - Otherwise: clear rep and increment iter_idx.
  - When iter_idx==ITER and no repeat is pending, the next state is DONE. iter_idx holds at ITER.
- DONE
  - ready=1, ms_sel=1, load_en=0, busy=0. iter_idx holds at ITER.
  - ack_fsm=1 moves the FSM to IDLE and clears iter_idx to 0.
- d_dir is combinational: d_dir = ~z_sign while in ITER, and 0 in every other state.
- Iteration cycles total ITER+2 (indices 4 and 13 each run twice). For ITER=16 that is 18 cycles.
- iter_idx never exceeds ITER, and there is no wrap-around.
- beg_fsm is ignored in LOAD, ITER and DONE. A start request is not queued.
- If ack_fsm and beg_fsm are both high in DONE, the FSM goes to IDLE. beg_fsm must be reasserted to start again.
- ack_fsm outside DONE is ignored.

## Timing
- Reset values: state=IDLE; ms_sel=0, load_en=0, iter_idx=0, busy=0, ready=0, d_dir=0.
- rst is asynchronous. Asserting it at any point, including mid-iteration, forces the reset values immediately. The FSM stays in IDLE while rst is high.
- Latency, with E0 as the rising edge that samples beg_fsm=1 in IDLE:
  - LOAD is active between E0 and E1.
  - ITER runs from E1 to E(ITER+3).
  - ready rises just after E(ITER+3); for ITER=16 that is E19.
- load_en is high for ITER+3 consecutive cycles: 1 LOAD cycle plus ITER+2 ITER cycles.
- The registers capture the iteration-(k) result on the edge that ends iteration cycle k.
- ready stays high until the edge that samples ack_fsm=1. It drops in the following cycle.
- The minimum restart is IDLE one cycle after ack_fsm, then beg_fsm on the next edge.

## Test plan
- Reset, then pulse beg_fsm for 1 cycle with ITER=16:
  - LOAD for 1 cycle with ms_sel=0.
  - iter_idx sequence 1,2,3,4,4,5,…,13,13,14,15,16 (18 values).
  - ready=1 at E19, with load_en high for exactly 19 cycles.
- Hold ack_fsm low for 10 cycles in DONE:
  - ready, iter_idx=16 and ms_sel=1 stay stable; load_en=0.
  - ack_fsm=1 gives IDLE on the next edge with iter_idx=0.
- Assert rst asynchronously while iter_idx=7:
  - All outputs go to 0 immediately.
  - After release, the FSM is in IDLE and does not restart without a new beg_fsm.
- Toggle beg_fsm during ITER, and drive ack_fsm and beg_fsm together in DONE:
  - The sequence is unaffected.
  - The FSM returns to IDLE, not LOAD.
- Drive z_sign with a random pattern:
  - d_dir = ~z_sign on every ITER cycle.
  - d_dir = 0 in IDLE, LOAD and DONE.
- Set ITER=13:
  - 15 iteration cycles, with index 13 repeated at the end.
  - ready at E16.
